// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI mode-0 slave with byte RX/TX streams.
// Define SPI_SLAVE_TX_FIFO_EN for a TX_DEPTH-entry TX FIFO instead of a single holding register.
module spi_slave_responder #(
  parameter int         TX_DEPTH  = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       rx_partial,
  output logic       tx_underrun,
  output logic [7:0] byte_count
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [2:0] cs_q, sck_q, bit_q, bit_d;
  logic [1:0] mosi_q, vld_q;
  logic armed_q, armed_d, oe_q, oe_d, rx_valid_q, rx_valid_d, fs_q, fs_d, fe_q, fe_d;
  logic rp_q, rp_d, ur_q, ur_d, tx_ready_q, tx_ready_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, tx_shift_q, tx_shift_d;
  logic [7:0] byte_cnt_q, byte_cnt_d, tx_head;
  logic cs_fall, cs_rise, sck_rise, sck_fall, load, pop, push, tx_empty;

  if (TX_DEPTH < 2 || TX_DEPTH > 16 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TX_DEPTH must be a power of two in 2..16");
  end

  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign push     = tx_valid & tx_ready_q;
  assign pop      = load & ~tx_empty;
  assign ur_d     = load & tx_empty;

  always_comb begin
    state_d    = state_q;
    // only a CS fall seen after a genuinely high CS may open a frame
    armed_d    = armed_q | (vld_q[1] & cs_q[1]);
    bit_d      = bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    tx_shift_d = tx_shift_q;
    byte_cnt_d = byte_cnt_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    rp_d       = 1'b0;
    load       = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall && armed_q) begin
        state_d    = ACTIVE;
        bit_d      = 3'd0;
        byte_cnt_d = 8'd0;
        fs_d       = 1'b1;
        oe_d       = 1'b1;
        load       = 1'b1;
      end
    end else if (cs_rise) begin
      state_d = IDLE;
      fe_d    = 1'b1;
      rp_d    = bit_q != 3'd0;
      bit_d   = 3'd0;
      oe_d    = 1'b0;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
      bit_d      = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
        byte_cnt_d = byte_cnt_q + 8'd1;
      end
    end else if (sck_fall) begin
      load       = bit_q == 3'd0;
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
    if (load) tx_shift_d = tx_empty ? IDLE_BYTE : tx_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q       <= 3'b111;
      sck_q      <= 3'b000;
      mosi_q     <= 2'b00;
      vld_q      <= 2'b00;
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      bit_q      <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      tx_shift_q <= 8'd0;
      byte_cnt_q <= 8'd0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      rp_q       <= 1'b0;
      ur_q       <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      cs_q       <= {cs_q[1:0], spi_cs_n};
      sck_q      <= {sck_q[1:0], spi_clk};
      mosi_q     <= {mosi_q[0], spi_mosi};
      vld_q      <= {vld_q[0], 1'b1};
      state_q    <= state_d;
      armed_q    <= armed_d;
      bit_q      <= bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_shift_q <= tx_shift_d;
      byte_cnt_q <= byte_cnt_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      rp_q       <= rp_d;
      ur_q       <= ur_d;
      tx_ready_q <= tx_ready_d;
    end
  end

`ifdef SPI_SLAVE_TX_FIFO_EN
  localparam int AW = $clog2(TX_DEPTH);
  logic [7:0]  mem_q [TX_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] fcnt_q, fcnt_d;
  assign tx_empty   = fcnt_q == '0;
  assign tx_head    = mem_q[rd_q];
  assign fcnt_d     = fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign tx_ready_d = fcnt_d < (AW+1)'(TX_DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= tx_data;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      fcnt_q <= fcnt_d;
    end
  end
`else
  logic [7:0] hold_q;
  logic full_q, full_d;
  assign tx_empty   = ~full_q;
  assign tx_head    = hold_q;
  assign full_d     = push | (full_q & ~pop);
  assign tx_ready_d = ~full_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 8'd0;
      full_q <= 1'b0;
    end else begin
      if (push) hold_q <= tx_data;
      full_q <= full_d;
    end
  end
`endif

  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign rx_partial  = rp_q;
  assign tx_underrun = ur_q;
  assign byte_count  = byte_cnt_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed SPI master stimulus checked against a byte-level queue model.
module tb_spi_slave_responder;
  logic clk = 0, rst = 1, spi_clk = 0, spi_cs_n = 1, spi_mosi = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic spi_miso, spi_miso_oe, tx_ready, rx_valid, frame_start, frame_end, rx_partial, tx_underrun;
  logic [7:0] rx_data, byte_count;

  spi_slave_responder dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .frame_start(frame_start),
    .frame_end(frame_end), .rx_partial(rx_partial), .tx_underrun(tx_underrun), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int fs_cnt = 0, fe_cnt = 0, rp_cnt = 0, ur_cnt = 0, rx_cnt = 0, ur_exp = 0;
  logic [7:0] txq[$], rxq[$];
  logic [7:0] mo[4], got[4], exp_mi[4];
  logic rdy_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // event monitor: every received byte must match the next byte the master sent
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt++;
        if (rxq.size() == 0) chk("rx_valid_unexpected", rx_valid, 0);
        else chk("rx_data_stream", rx_data, rxq.pop_front());
      end
      if (rx_partial) chk("rx_partial_with_frame_end", frame_end, 1);
      fs_cnt += int'(frame_start);
      fe_cnt += int'(frame_end);
      rp_cnt += int'(rx_partial);
      ur_cnt += int'(tx_underrun);
    end
  end

  task automatic check_reset(input string p);
    chk({p, "_miso"}, spi_miso, 0);
    chk({p, "_miso_oe"}, spi_miso_oe, 0);
    chk({p, "_rx_data"}, rx_data, 0);
    chk({p, "_rx_valid"}, rx_valid, 0);
    chk({p, "_tx_ready"}, tx_ready, 1);
    chk({p, "_pulses"}, {frame_start, frame_end, rx_partial, tx_underrun}, 0);
    chk({p, "_byte_count"}, byte_count, 0);
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("push_ready_timeout", tx_ready, 1);
    else begin
      tx_data = b;
      tx_valid = 1;
      @(negedge clk);
      tx_valid = 0;
      txq.push_back(b);
    end
  endtask

  task automatic toggle(input int n);
    for (int k = 0; k < n; k++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      spi_clk = 1;
      repeat (4) @(negedge clk);
      spi_clk = 0;
    end
  endtask

  // mode-0 master; the last SCLK fall coincides with CS rise, so no extra load follows the frame
  task automatic frame(input int nbits, input bit mid_push, input logic [7:0] mp);
    int fs0 = fs_cnt, fe0 = fe_cnt, rp0 = rp_cnt, ur0 = ur_cnt;
    ur_exp = 0;
    spi_cs_n = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) begin
        if (txq.size() > 0) exp_mi[i/8] = txq.pop_front();
        else begin
          exp_mi[i/8] = 8'hFF;
          ur_exp++;
        end
      end
      spi_mosi = mo[i/8][7 - i%8];
      repeat (4) @(negedge clk);
      got[i/8][7 - i%8] = spi_miso;
      if (i == 0) begin
        chk("miso_oe_active", spi_miso_oe, 1);
        rdy_first = tx_ready;
      end
      spi_clk = 1;
      if (i % 8 == 7) rxq.push_back(mo[i/8]);
      repeat (4) @(negedge clk);
      if (i == 0 && mid_push) push(mp);
      if (i == nbits - 1) spi_cs_n = 1;
      spi_clk = 0;
    end
    repeat (6) @(negedge clk);
    chk("frame_start_count", fs_cnt - fs0, 1);
    chk("frame_end_count", fe_cnt - fe0, 1);
    chk("rx_partial_count", rp_cnt - rp0, (nbits % 8 != 0) ? 1 : 0);
    chk("tx_underrun_count", ur_cnt - ur0, ur_exp);
    chk("byte_count", byte_count, nbits / 8);
    chk("rx_bytes_all_seen", rxq.size(), 0);
    chk("miso_oe_after", spi_miso_oe, 0);
    for (int j = 0; j < nbits / 8; j++) chk("miso_byte", got[j], exp_mi[j]);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_fs, s_fe, s_ur, s_rx;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 0;
    repeat (4) @(negedge clk);

    push(8'hA5);
`ifdef SPI_SLAVE_TX_FIFO_EN
    chk("tx_ready_one_queued", tx_ready, 1);
`else
    chk("tx_ready_holding_full", tx_ready, 0);
`endif
    mo[0] = 8'hDE;
    mo[1] = 8'hDD;
    frame(16, 1, 8'h5A);
    chk("two_byte_miso0", got[0], 8'hA5);
    chk("two_byte_miso1", got[1], 8'h5A);
    chk("two_byte_rx_last", rx_data, 8'hDD);
    chk("two_byte_rx_partial", rp_cnt, 0);

    s_ur = ur_cnt;
    mo[0] = 8'h12;
    mo[1] = 8'h34;
    frame(16, 0, 8'h00);
    chk("underrun_miso0", got[0], 8'hFF);
    chk("underrun_miso1", got[1], 8'hFF);
    chk("underrun_pulses", ur_cnt - s_ur, 2);

    s_rx = rx_cnt;
    mo[0] = 8'hB7;
    frame(5, 0, 8'h00);
    chk("partial_no_rx", rx_cnt - s_rx, 0);
    mo[0] = 8'h3C;
    frame(8, 0, 8'h00);
    chk("after_partial_rx", rx_data, 8'h3C);

    push(8'h3A);
    s_fs = fs_cnt; s_fe = fe_cnt; s_ur = ur_cnt; s_rx = rx_cnt;
    toggle(16);
    repeat (6) @(negedge clk);
    chk("idle_sclk_no_rx", rx_cnt - s_rx, 0);
    chk("idle_sclk_no_frames", (fs_cnt - s_fs) + (fe_cnt - s_fe), 0);
    chk("idle_sclk_no_underrun", ur_cnt - s_ur, 0);
    chk("idle_sclk_oe", spi_miso_oe, 0);
`ifdef SPI_SLAVE_TX_FIFO_EN
    chk("idle_sclk_tx_ready", tx_ready, 1);
`else
    chk("idle_sclk_tx_ready", tx_ready, 0);
`endif
    mo[0] = 8'h81;
    frame(8, 0, 8'h00);
    chk("idle_sclk_buffer_kept", got[0], 8'h3A);

`ifdef SPI_SLAVE_TX_FIFO_EN
    for (int k = 1; k <= 4; k++) begin
      push(8'(k));
      chk("fifo_tx_ready", tx_ready, (k < 4) ? 1 : 0);
    end
    tx_data = 8'h05;
    tx_valid = 1;
    repeat (3) @(negedge clk);
    tx_valid = 0;
    chk("fifo_full_tx_ready", tx_ready, 0);
    for (int k = 0; k < 4; k++) mo[k] = 8'(8'h60 + k);
    frame(32, 0, 8'h00);
    chk("fifo_ready_after_pop", rdy_first, 1);
    for (int k = 0; k < 4; k++) chk("fifo_order", got[k], 8'(k + 1));
`endif

    spi_cs_n = 0;
    toggle(3);
    rst = 1;
    repeat (2) @(negedge clk);
    check_reset("midreset");
    rst = 0;
    txq.delete();
    rxq.delete();
    repeat (2) @(negedge clk);
    s_fs = fs_cnt; s_fe = fe_cnt; s_rx = rx_cnt;
    toggle(8);
    repeat (6) @(negedge clk);
    chk("midreset_no_rx", rx_cnt - s_rx, 0);
    chk("midreset_no_start", fs_cnt - s_fs, 0);
    chk("midreset_oe", spi_miso_oe, 0);
    spi_cs_n = 1;
    repeat (6) @(negedge clk);
    chk("midreset_no_end", fe_cnt - s_fe, 0);
    push(8'hC3);
    mo[0] = 8'h96;
    frame(8, 0, 8'h00);
    chk("midreset_next_miso", got[0], 8'hC3);
    chk("midreset_next_rx", rx_data, 8'h96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI mode-0 slave, fully oversampled in the system clock domain, forming the far end of the SPI master path in the CDC command design. It deserialises MOSI into bytes for the fabric and serialises fabric-supplied bytes onto MISO. It serves as the on-board target for master loopback and as a device-emulation endpoint.

## Interface
Parameters:
- TX_DEPTH, 4: TX FIFO depth in bytes (power of two, 2..16); used only when SPI_SLAVE_TX_FIFO_EN is defined.
- IDLE_BYTE, 8'hFF: byte shifted out on TX underrun.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- spi_clk  in  1  SCLK from master, asynchronous.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable (tri-state control at top level).
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block can accept tx_data; a byte transfers when tx_valid & tx_ready.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  one-cycle strobe, rx_data new.
- frame_start  out  1  one-cycle pulse on CS assert.
- frame_end  out  1  one-cycle pulse on CS deassert.
- rx_partial  out  1  one-cycle pulse with frame_end if the frame ended mid-byte.
- tx_underrun  out  1  one-cycle pulse when a load found no TX byte.
- byte_count  out  8  completed RX bytes in current frame, wraps 255->0.

## Operation
- spi_cs_n, spi_clk, spi_mosi each pass through two-flop synchronisers; reset values 1, 0, 0. Edges are detected against a third registered copy (reset 1 for CS, 0 for SCLK).
- States: IDLE (CS high) and ACTIVE (CS low). IDLE->ACTIVE on synchronised CS falling edge only; a CS level that is low at reset release is ignored until CS rises and falls again.
- On CS fall: bit_cnt=0, byte_count=0, frame_start pulse, spi_miso_oe=1, load TX shift register (pop TX head, or IDLE_BYTE plus tx_underrun), spi_miso=shift[7].
- SCLK rising in ACTIVE: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++. When bit_cnt==7: rx_data <= assembled byte, rx_valid=1, byte_count++, bit_cnt->0.
- SCLK falling in ACTIVE: if bit_cnt==0 (byte boundary), load next TX byte (pop or IDLE_BYTE + tx_underrun); otherwise shift TX left. spi_miso always drives shift[7]. MSB first.
- On CS rise: frame_end pulse; rx_partial if bit_cnt!=0; partial RX bits discarded; bit_cnt=0; spi_miso_oe=0. byte_count holds until the next CS fall.
- SCLK edges while IDLE are ignored.
- TX pop and push in the same cycle: the pop sees pre-push contents (no bypass). Pop from an empty buffer gives underrun even if tx_valid is high in the same cycle; the pushed byte is kept.

## Timing
- Reset values: spi_miso 0, spi_miso_oe 0, rx_data 0, rx_valid 0, tx_ready 1, frame_start 0, frame_end 0, rx_partial 0, tx_underrun 0, byte_count 0, TX buffer empty.
- Latency from a pin edge to its internal action is 3 clk cycles: 2 sync cycles plus 1 edge-detect cycle. rx_valid is high on cycle 3 after the 8th SCLK rising edge. spi_miso updates on cycle 3 after an SCLK falling edge or CS falling edge.
- SCLK high and low times must each be >= 4 clk periods. CS setup before the first SCLK edge must be >= 4 clk periods.
- tx_ready is registered and reflects occupancy at the start of the cycle. tx_ready deasserts in the cycle after the push that fills the buffer.
- Reset mid-frame aborts everything: no rx_valid and no frame_end for the aborted frame.

## Configuration
- SPI_SLAVE_TX_FIFO_EN defined: TX buffer is a TX_DEPTH-entry FIFO; tx_ready = count < TX_DEPTH.
- SPI_SLAVE_TX_FIFO_EN undefined: TX buffer is a single holding register; tx_ready = holding register empty; TX_DEPTH is ignored. All other behaviour is identical.

## Test plan
- Two-byte transfer: push 0xA5, 0x5A; master sends 0xDE, 0xDD at SCLK = clk/8. Required: rx_valid twice with 0xDE then 0xDD; master reads 0xA5, 0x5A; byte_count=2; one frame_start and one frame_end; rx_partial=0.
- Underrun: TX empty, master runs a 2-byte frame. Required: MISO reads 0xFF, 0xFF; tx_underrun pulses twice (at CS fall and at the byte boundary).
- Partial byte: CS rises after 5 SCLK cycles. Required: no rx_valid; frame_end and rx_partial in the same cycle; next full frame sending 0x3C gives rx_data=0x3C.
- Buffer full (FIFO build, TX_DEPTH=4): push 0x01..0x04. Required: tx_ready low after the 4th push; a 5th tx_valid is not accepted; tx_ready returns after the first pop; MISO carries 0x01..0x04 in order.
- Reset mid-frame: assert rst after 3 bits with CS held low. Required: all outputs at reset values; SCLK activity causes no rx_valid until CS rises and falls; the next frame works normally.
- SCLK toggling 16 times with CS high. Required: no rx_valid, no frame pulses, spi_miso_oe stays 0, TX buffer untouched.
